// File: rtl/io_irq_ctrl_pkg.sv
// Shared definitions for the j1 interrupt controller: FSM states, write opcodes
// and the layout of the status word returned on io_din.
package io_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRE    = 2'd1,
    ST_SERVICE = 2'd2,
    ST_GAP     = 2'd3
  } irq_state_e;

  // Opcode lives in io_dout[15:14] of a write to this block
  localparam logic [1:0] OP_ENABLE = 2'b00;
  localparam logic [1:0] OP_W1C    = 2'b01;
  localparam logic [1:0] OP_GIE    = 2'b10;
  localparam logic [1:0] OP_SWTRIG = 2'b11;

  localparam int FIELD_W     = 7;
  localparam int RD_EN_LSB   = 0;
  localparam int RD_IRQ_BIT  = 7;
  localparam int RD_PEND_LSB = 8;
  localparam int RD_GIE_BIT  = 15;

  function automatic logic [15:0] pack_status(input logic               gie,
                                              input logic [FIELD_W-1:0] pend,
                                              input logic               irq,
                                              input logic [FIELD_W-1:0] en);
    logic [15:0] w;
    w                          = '0;
    w[RD_GIE_BIT]              = gie;
    w[RD_PEND_LSB +: FIELD_W]  = pend;
    w[RD_IRQ_BIT]              = irq;
    w[RD_EN_LSB +: FIELD_W]    = en;
    return w;
  endfunction

endpackage

// File: rtl/io_irq_ctrl_edge.sv
// Rising-edge detect plus sticky pending bits, one lane per interrupt source.
// A hardware edge and a W1C on the same bit in the same cycle leave it pending.
module irq_edge_latch
  import io_irq_ctrl_pkg::*;
#(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] src_i,
  input  logic [N-1:0] set_i,
  input  logic [N-1:0] clr_i,
  output logic [N-1:0] pending_o
);

  logic [N-1:0] src_q;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] rise;

  always_comb begin
    rise   = src_i & ~src_q;
    pend_d = (pend_q & ~clr_i) | rise | set_i;
  end

  // src_q keeps tracking during reset so a level already high at exit is not an edge
  always_ff @(posedge clk) begin
    src_q <= src_i;
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/io_irq_ctrl.sv
// j1 I/O-bus interrupt controller: sticky masked sources, one-cycle request
// pulse, wait for acknowledge, then a fixed holdoff before it may fire again.
module io_irq_ctrl
  import io_irq_ctrl_pkg::*;
#(
  parameter int NSRC    = 7,
  parameter int SEL_BIT = 15,
  parameter int HOLDOFF = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            io_rd,
  input  logic            io_wr,
  input  logic [15:0]     io_addr,
  input  logic [15:0]     io_dout,
  output logic [15:0]     io_din,
  input  logic [NSRC-1:0] irq_src,
  output logic            interrupt_request
);

  localparam logic [7:0] HoldLoad = 8'(HOLDOFF - 1);

  irq_state_e         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NSRC-1:0]    enable_q, enable_d;
  logic               gie_q, gie_d;
  logic [NSRC-1:0]    pending, swSet, w1cClr;
  logic               sel, wrEn, active;
  logic [1:0]         op;
  logic [FIELD_W-1:0] pendRd, enRd;
  logic               unused_bits;

  assign sel         = io_addr[SEL_BIT];
  assign wrEn        = io_wr & sel;
  assign op          = io_dout[15:14];
  assign unused_bits = ^{io_rd, io_addr, io_dout};

  always_comb begin
    enable_d = enable_q;
    gie_d    = gie_q;
    swSet    = '0;
    w1cClr   = '0;
    if (wrEn) begin
      case (op)
        OP_ENABLE: enable_d = io_dout[NSRC-1:0];
        OP_W1C:    w1cClr   = io_dout[NSRC-1:0];
        OP_GIE:    gie_d    = io_dout[0];
        OP_SWTRIG: swSet    = io_dout[NSRC-1:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= '0;
      gie_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      gie_q    <= gie_d;
    end
  end

  irq_edge_latch #(.N(NSRC)) u_edge (
    .clk      (clk),
    .reset    (reset),
    .src_i    (irq_src),
    .set_i    (swSet),
    .clr_i    (w1cClr),
    .pending_o(pending)
  );

  assign active = gie_q & (|(pending & enable_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Level-sensitive in IDLE, so unmasking an already-pending bit also fires
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:    if (active) state_d = ST_FIRE;
      ST_FIRE:    state_d = ST_SERVICE;
      ST_SERVICE: begin
        if (!active) begin
          state_d = ST_GAP;
          cnt_d   = HoldLoad;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    interrupt_request = (state_q == ST_FIRE);
  end

  always_comb begin
    pendRd             = '0;
    enRd               = '0;
    pendRd[NSRC-1:0]   = pending;
    enRd[NSRC-1:0]     = enable_q;
    io_din = sel ? pack_status(gie_q, pendRd, interrupt_request, enRd) : 16'd0;
  end

endmodule

// File: tb/tb_io_irq_ctrl.sv
// Directed bench for io_irq_ctrl: a cycle-by-cycle vector table followed by
// hand-written latency and reset-suppression sequences.
module tb_io_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, io_dout, io_din;
  logic [6:0]  irq_src;
  logic        interrupt_request;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [6:0]  src;
    logic        expIrq;
    logic [15:0] expDin;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  io_irq_ctrl #(.NSRC(7), .SEL_BIT(15), .HOLDOFF(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .io_rd            (io_rd),
    .io_wr            (io_wr),
    .io_addr          (io_addr),
    .io_dout          (io_dout),
    .io_din           (io_din),
    .irq_src          (irq_src),
    .interrupt_request(interrupt_request)
  );

  // Safety net so a stuck run still ends with a visible failure
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input logic wr, input logic [15:0] addr, input logic [15:0] dout,
                        input logic [6:0] src, input logic expIrq, input logic [15:0] expDin);
    vec_t v;
    v.wr = wr; v.addr = addr; v.dout = dout; v.src = src;
    v.expIrq = expIrq; v.expDin = expDin;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic wr, input logic [15:0] addr,
                               input logic [15:0] dout, input logic [6:0] src);
    io_wr   = wr;
    io_rd   = ~wr;
    io_addr = addr;
    io_dout = dout;
    irq_src = src;
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    nChecks++;
    if (got != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [15:0] data);
    applyStimulus(1'b1, 16'h8000, data, irq_src);
    tick();
    applyStimulus(1'b0, 16'h8000, 16'h0000, irq_src);
  endtask

  initial begin
    int lat;
    int highCount;

    // wr, addr, dout, src, expected irq, expected io_din (state before the row's edge)
    addVec(0, 16'h8000, 16'h0000, 7'h01, 0, 16'h0000);
    addVec(0, 16'h8000, 16'h0000, 7'h01, 0, 16'h0000);
    addVec(1, 16'h8000, 16'h0001, 7'h00, 0, 16'h0000);
    addVec(1, 16'h8000, 16'h8001, 7'h00, 0, 16'h0001);
    addVec(0, 16'h8000, 16'h0000, 7'h01, 0, 16'h8001);
    addVec(0, 16'h8000, 16'h0000, 7'h01, 0, 16'h8101);
    addVec(0, 16'h8000, 16'h0000, 7'h01, 1, 16'h8181);
    addVec(1, 16'h8000, 16'h0003, 7'h00, 0, 16'h8101);
    addVec(0, 16'h8000, 16'h0000, 7'h01, 0, 16'h8103);
    addVec(1, 16'h8000, 16'h4001, 7'h01, 0, 16'h8103);
    addVec(0, 16'h8000, 16'h0000, 7'h01, 0, 16'h8003);
    addVec(1, 16'h8000, 16'h4002, 7'h03, 0, 16'h8003);
    addVec(0, 16'h8000, 16'h0000, 7'h03, 0, 16'h8203);
    addVec(0, 16'h8000, 16'h0000, 7'h03, 0, 16'h8203);
    addVec(0, 16'h8000, 16'h0000, 7'h03, 0, 16'h8203);
    addVec(0, 16'h8000, 16'h0000, 7'h03, 0, 16'h8203);
    addVec(0, 16'h8000, 16'h0000, 7'h03, 1, 16'h8283);
    addVec(1, 16'h8000, 16'h4002, 7'h03, 0, 16'h8203);
    addVec(0, 16'h8000, 16'h0000, 7'h03, 0, 16'h8003);
    addVec(1, 16'h8000, 16'h0000, 7'h03, 0, 16'h8003);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 0, 16'h8000);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 0, 16'h8400);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 0, 16'h8400);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 0, 16'h8400);
    addVec(1, 16'h8000, 16'h0004, 7'h07, 0, 16'h8400);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 0, 16'h8404);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 1, 16'h8484);
    addVec(1, 16'h8000, 16'h4004, 7'h07, 0, 16'h8404);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 0, 16'h8004);
    addVec(1, 16'h8000, 16'h0010, 7'h07, 0, 16'h8004);
    addVec(1, 16'h0001, 16'h0000, 7'h07, 0, 16'h0000);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 0, 16'h8010);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 0, 16'h8010);
    addVec(1, 16'h8000, 16'hC010, 7'h07, 0, 16'h8010);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 0, 16'h9010);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 1, 16'h9090);
    addVec(0, 16'h8000, 16'h0000, 7'h07, 0, 16'h9010);

    reset = 1'b1;
    applyStimulus(1'b0, 16'h8000, 16'h0000, 7'h01);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].dout, vecs[i].src);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_irq", i), int'(interrupt_request), int'(vecs[i].expIrq));
      checkOutput($sformatf("vec%0d_din", i), int'(io_din), int'(vecs[i].expDin));
      tick();
    end

    // Reset while in SERVICE: everything cleared, no spurious pulse afterwards
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_service_irq", int'(interrupt_request), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_service_din", int'(io_din), 16'h0000);
    tick();
    highCount = 0;
    for (int k = 0; k < 6; k++) begin
      if (interrupt_request) highCount++;
      tick();
    end
    checkOutput("rst_service_quiet", highCount, 0);

    // Edge-to-pulse latency and pulse width
    applyStimulus(1'b0, 16'h8000, 16'h0000, 7'h00);
    tick();
    busWrite(16'h0001);
    busWrite(16'h8001);
    irq_src = 7'h01;
    lat = 0;
    highCount = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (interrupt_request) begin
        highCount++;
        if (lat == 0) lat = k;
      end
    end
    checkOutput("edge_latency", lat, 2);
    checkOutput("pulse_width", highCount, 1);

    // Reset in the cycle that would enter FIRE must swallow the pulse
    busWrite(16'h4001);
    repeat (8) tick();
    irq_src = 7'h00;
    tick();
    irq_src = 7'h01;
    tick();
    reset = 1'b1;
    tick();
    checkOutput("rst_suppress_irq", int'(interrupt_request), 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_pending_lost", int'(io_din), 16'h0000);
    tick();
    highCount = 0;
    for (int k = 0; k < 6; k++) begin
      if (interrupt_request) highCount++;
      tick();
    end
    checkOutput("rst_suppress_quiet", highCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
